// File: rtl/sram_req_ctrl.sv
// Request controller for a read-first, registered-output SRAM macro.
// Define SRAM_INIT_CLEAR_EN to zero the whole array after every reset.
module sram_req_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i,
  output logic                  busy_o
);

  localparam int unsigned CntW = $clog2(RD_LAT + 2);
  localparam logic [CntW-1:0] CntLoad = CntW'(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StResp, StInit} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  sram_we_q, sram_we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_din_q, sram_din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  ready;
  logic                  accept;

`ifdef SRAM_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic                  init_done_q, init_done_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sram_we_d   = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    ready       = 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
`endif

    unique case (state_q)
      StIdle: ready = 1'b1;
      StRdWait: begin
        cnt_d = cnt_q - CntW'(1);
        // Counter reaches zero on this edge: macro output is valid now.
        if (cnt_q == CntW'(1)) begin
          rsp_rdata_d = sram_dout_i;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        ready = rsp_ready_i;
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StInit: begin
`ifdef SRAM_INIT_CLEAR_EN
        // One extra cycle after the last address lets sram_we drop before IDLE.
        if (init_done_q) begin
          state_d = StIdle;
        end else begin
          sram_we_d   = 1'b1;
          sram_addr_d = init_addr_q;
          sram_din_d  = '0;
          init_addr_d = init_addr_q + ADDR_WIDTH'(1);
          if (init_addr_q == '1) begin
            init_done_d = 1'b1;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    // A request may be taken in the same cycle as a response handshake.
    accept = ready && req_valid_i;
    if (accept) begin
      sram_addr_d = req_addr_i;
      if (req_we_i) begin
        sram_we_d  = 1'b1;
        sram_din_d = req_wdata_i;
      end else begin
        state_d = StRdWait;
        cnt_d   = CntLoad;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
`ifdef SRAM_INIT_CLEAR_EN
      state_q     <= StInit;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
`else
      state_q     <= StIdle;
`endif
      cnt_q       <= '0;
      sram_we_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
`ifdef SRAM_INIT_CLEAR_EN
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
`endif
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sram_we_q   <= sram_we_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Gate the state-decoded outputs so every output reads 0 while reset is held.
  assign req_ready_o = ready && !rst_i;
  assign busy_o      = (state_q != StIdle) && !rst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign sram_we_o   = sram_we_q;
  assign sram_addr_o = sram_addr_q;
  assign sram_din_o  = sram_din_q;

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Upstream request controller for the mixed-signal SRAM macro (clk/we/addr/din/dout, read-first, registered output).
- Accepts read/write requests over a valid/ready interface and drives the macro port from registered outputs.
- Captures read data after the macro's read latency and returns it over a valid/ready response interface with backpressure.
- Sits between the digital request fabric and the SRAM macro in the same clock domain.

Parameters:
DATA_WIDTH, 8, word width; matches the macro.
ADDR_WIDTH, 4, address width; depth is 2**ADDR_WIDTH.
RD_LAT, 1, number of clk edges after the macro samples a read address before sram_dout is valid; legal range 1..4.

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  request address.
req_wdata  in  DATA_WIDTH  write data (ignored for reads).
rsp_valid  out  1  read data available.
rsp_ready  in  1  consumer takes the response.
rsp_rdata  out  DATA_WIDTH  read data.
sram_we  out  1  to macro we.
sram_addr  out  ADDR_WIDTH  to macro addr.
sram_din  out  DATA_WIDTH  to macro din.
sram_dout  in  DATA_WIDTH  from macro dout.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, sram_we, sram_addr, sram_din, busy.
  - State goes to IDLE, or to INIT when INIT_CLEAR_EN is defined.
  - Any pending read is discarded.
- FSM states:
  - INIT (optional): see Optional Feature.
  - IDLE: req_ready = 1.
    - Write accept at edge N: sram_we = 1, sram_addr and sram_din are loaded and held through the cycle; the macro samples at edge N+1. sram_we returns to 0 at edge N+1 unless another write is accepted at N+1.
    - Back-to-back writes are sustained at 1 per cycle; state stays IDLE.
    - Read accept at edge N: sram_we = 0, sram_addr loaded, go to RD_WAIT, load counter with RD_LAT+1.
  - RD_WAIT: req_ready = 0. Counter decrements each edge.
    - On the edge where the counter reaches 0 (edge N+1+RD_LAT), rsp_rdata <= sram_dout, rsp_valid <= 1, go to RESP.
    - With RD_LAT = 1, rsp_valid is high in the cycle after edge N+2.
  - RESP: rsp_valid and rsp_rdata are held stable until rsp_valid && rsp_ready.
    - req_ready = rsp_ready (combinational path permitted). A new request may be accepted in the same cycle as the response handshake.
    - On handshake: rsp_valid <= 0. Next state is IDLE, or RD_WAIT / stay-IDLE-write handling per the request accepted in that cycle.
- Write-then-read to the same address (accepts at N and N+1) returns the new data; no hazard logic is needed.
- A read blocks further requests until its response is consumed, so read-first write hazards cannot occur.
- Counter width: clog2(RD_LAT+2). Address and data pass through unmodified; no wrap logic outside INIT.
- Reset mid-RD_WAIT or mid-RESP: rsp_valid drops immediately and asynchronously; no response is ever produced for that read.
- req_valid while req_ready = 0: ignored. The requester must hold the request stable.

Optional Feature:
- Macro: SRAM_INIT_CLEAR_EN.
- Defined:
  - After reset release, the FSM enters INIT and writes 0 to addresses 0 .. 2**ADDR_WIDTH-1, one per cycle (sram_we = 1, sram_din = 0, sram_addr incrementing).
  - During INIT: req_ready = 0, busy = 1.
  - After the last address (16 cycles by default), sram_we drops and the FSM enters IDLE.
  - Reset during INIT restarts the clear from address 0.
- Undefined: no INIT state; IDLE is entered directly after reset and memory contents are unspecified.

Test Plan:
1. Reset check: assert rst for 3 cycles, then release. All outputs read 0 during reset; req_ready = 1 and busy = 0 on the first cycle after release (macro undefined).
2. Write then read: write addr 3 data 0xAA, then read addr 3. Expect rsp_valid exactly 2 edges after the read accept edge (RD_LAT = 1), rsp_rdata = 0xAA.
3. Throughput: back-to-back writes to addr 0..15 with data addr*0x11 complete in 16 consecutive cycles with req_ready constantly 1. Reads of all 16 addresses then return 0x00, 0x11 .. 0xFF.
4. Backpressure: read addr 5 with rsp_ready low for 5 cycles. rsp_valid and rsp_rdata stay stable and req_ready = 0. Then raise rsp_ready with a pending read of addr 6: response handshake and new accept occur in the same cycle.
5. Reset mid-read: assert rst one cycle after a read accept. rsp_valid never rises, sram_we = 0, and req_ready = 1 after release.
6. SRAM_INIT_CLEAR_EN: after reset, observe 16 cycles of sram_we = 1, sram_addr 0..15, sram_din = 0, with req_ready = 0. Then write addr 3 0x55 and read addr 4: expect 0x00.
